hand_score_acc: RTL and testbench

Registered, multi-hand successor to the combinational three-card scorer. It accumulates baccarat hand scores one card at a time for `N_HANDS` independent hands, each holding up to `MAX_CARDS` cards. Per hand it keeps a mod-10 score, a card count, a natural flag and a full flag. It sits between the card dealer and the game-control FSM; the FSM consumes its registered outputs instead of recomputing the sum of three cards.

---
 rtl/baccarat_pkg.sv | 13 +
 rtl/card_value.sv | 22 ++
 rtl/hand_score_acc.sv | 92 +++++++++
 tb/tb_hand_score_acc.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/baccarat_pkg.sv
// Shared card/score types and constants for the baccarat hand scoring logic.
package baccarat_pkg;

  typedef logic [3:0] card_t;
  typedef logic [3:0] score_t;

  localparam card_t  CARD_ACE    = 4'd1;
  localparam card_t  CARD_TEN    = 4'd10;
  localparam card_t  CARD_KING   = 4'd13;
  localparam score_t SCORE_MOD   = 4'd10;
  localparam score_t NATURAL_MIN = 4'd8;

endpackage

// File: rtl/card_value.sv
// Maps a card rank code to its baccarat point value and flags illegal codes.
import baccarat_pkg::*;

module card_value (
  input  card_t  card,
  output score_t value,
  output logic   legal
);

  always_comb begin
    value = '0;
    legal = 1'b0;
    if (card >= CARD_ACE && card < CARD_TEN) begin
      value = card;
      legal = 1'b1;
    end else if (card >= CARD_TEN && card <= CARD_KING) begin
      // Tens and court cards count as zero.
      legal = 1'b1;
    end
  end

endmodule

// File: rtl/hand_score_acc.sv
// Accumulates mod-10 baccarat scores card by card for N_HANDS independent hands.
//   state   | meaning
//   EMPTY   | count == 0
//   PARTIAL | 0 < count < MAX_CARDS
//   FULL    | count == MAX_CARDS, further cards rejected until clear/reset
import baccarat_pkg::*;

module hand_score_acc #(
  parameter int N_HANDS   = 2,
  parameter int MAX_CARDS = 3,
  parameter int CNT_W     = $clog2(MAX_CARDS + 1),
  parameter int HAND_W    = (N_HANDS > 1) ? $clog2(N_HANDS) : 1
) (
  input  logic                     slow_clock,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     card_valid,
  input  logic [HAND_W-1:0]        card_hand,
  input  card_t                    card,
  output logic                     card_ready,
  output logic [N_HANDS*4-1:0]     score,
  output logic [N_HANDS*CNT_W-1:0] count,
  output logic [N_HANDS-1:0]       natural,
  output logic [N_HANDS-1:0]       full,
  output logic                     err
);

  localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_CARDS);
  localparam logic [CNT_W-1:0]  TWO_CNT   = CNT_W'(2);
  localparam logic [HAND_W:0]   N_HANDS_W = (HAND_W + 1)'(N_HANDS);

  score_t           score_r [N_HANDS];
  logic [CNT_W-1:0] count_r [N_HANDS];

  score_t     val;
  logic       legal;
  logic       accept;
  logic       hand_ok;
  logic       room_ok;
  logic [4:0] sum;
  score_t     next_score;

  card_value u_card_value (
    .card  (card),
    .value (val),
    .legal (legal)
  );

  assign card_ready = !clear && !reset;
  assign accept     = card_valid && card_ready;
  assign hand_ok    = {1'b0, card_hand} < N_HANDS_W;

  always_comb begin
    room_ok    = 1'b0;
    sum        = '0;
    next_score = '0;
    if (hand_ok) begin
      room_ok    = count_r[card_hand] < MAX_CNT;
      sum        = {1'b0, score_r[card_hand]} + {1'b0, val};
      // Max sum is 18, so a single conditional subtraction suffices.
      next_score = (sum >= {1'b0, SCORE_MOD}) ? 4'(sum - {1'b0, SCORE_MOD}) : sum[3:0];
    end
  end

  always_ff @(posedge slow_clock) begin
    if (reset || clear) begin
      for (int i = 0; i < N_HANDS; i++) begin
        score_r[i] <= '0;
        count_r[i] <= '0;
      end
      err <= 1'b0;
    end else begin
      err <= 1'b0;
      if (accept) begin
        if (legal && hand_ok && room_ok) begin
          score_r[card_hand] <= next_score;
          count_r[card_hand] <= count_r[card_hand] + 1'b1;
        end else begin
          err <= 1'b1;
        end
      end
    end
  end

  for (genvar i = 0; i < N_HANDS; i++) begin : g_hand
    assign score[4*i +: 4]         = score_r[i];
    assign count[CNT_W*i +: CNT_W] = count_r[i];
    assign natural[i]              = (count_r[i] == TWO_CNT) && (score_r[i] >= NATURAL_MIN);
    assign full[i]                 = (count_r[i] == MAX_CNT);
  end

endmodule

// File: tb/tb_hand_score_acc.sv
// Directed scoreboard bench for hand_score_acc with two hands of three cards.
module tb_hand_score_acc;

  logic       slow_clock;
  logic       reset;
  logic       clear;
  logic       card_valid;
  logic [0:0] card_hand;
  logic [3:0] card;
  logic       card_ready;
  logic [7:0] score;
  logic [3:0] count;
  logic [1:0] natural;
  logic [1:0] full;
  logic       err;

  typedef struct {
    logic [7:0] score;
    logic [3:0] count;
    logic [1:0] natural;
    logic [1:0] full;
    logic       err;
    logic       ready;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  hand_score_acc dut (
    .slow_clock (slow_clock),
    .reset      (reset),
    .clear      (clear),
    .card_valid (card_valid),
    .card_hand  (card_hand),
    .card       (card),
    .card_ready (card_ready),
    .score      (score),
    .count      (count),
    .natural    (natural),
    .full       (full),
    .err        (err)
  );

  initial slow_clock = 1'b0;
  always #5 slow_clock = ~slow_clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  // Drive one cycle of stimulus and queue the hand-computed state seen after the edge.
  task automatic step(input logic rst, input logic clr, input logic v, input logic h,
                      input logic [3:0] c, input logic [3:0] s0, input logic [3:0] s1,
                      input logic [1:0] c0, input logic [1:0] c1, input logic [1:0] nat,
                      input logic [1:0] ful, input logic e, input logic rdy);
    exp_t x;
    @(negedge slow_clock);
    reset      = rst;
    clear      = clr;
    card_valid = v;
    card_hand  = h;
    card       = c;
    x.score    = {s1, s0};
    x.count    = {c1, c0};
    x.natural  = nat;
    x.full     = ful;
    x.err      = e;
    x.ready    = rdy;
    exp_q.push_back(x);
  endtask

  initial begin
    exp_t x;
    forever begin
      @(posedge slow_clock);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("score",      32'(score),      32'(x.score));
        chk("count",      32'(count),      32'(x.count));
        chk("natural",    32'(natural),    32'(x.natural));
        chk("full",       32'(full),       32'(x.full));
        chk("err",        32'(err),        32'(x.err));
        chk("card_ready", 32'(card_ready), 32'(x.ready));
      end
    end
  end

  initial begin
    reset = 1'b1; clear = 1'b0; card_valid = 1'b0; card_hand = 1'b0; card = 4'd0;
    //   rst clr v  h  card   s0 s1 c0 c1 nat    full   err rdy
    step(1, 0, 0, 0, 4'd0,  0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    step(1, 0, 1, 0, 4'd5,  0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    step(0, 0, 0, 0, 4'd0,  0, 0, 0, 0, 2'b00, 2'b00, 0, 1);
    // Player 9 + 9 -> natural 8
    step(0, 0, 1, 0, 4'd9,  9, 0, 1, 0, 2'b00, 2'b00, 0, 1);
    step(0, 0, 1, 0, 4'd9,  8, 0, 2, 0, 2'b01, 2'b00, 0, 1);
    // Dealer 10, Q, K -> score 0, full
    step(0, 0, 1, 1, 4'd10, 8, 0, 2, 1, 2'b01, 2'b00, 0, 1);
    step(0, 0, 1, 1, 4'd12, 8, 0, 2, 2, 2'b01, 2'b00, 0, 1);
    step(0, 0, 1, 1, 4'd13, 8, 0, 2, 3, 2'b01, 2'b10, 0, 1);
    // Card to a full hand is rejected
    step(0, 0, 1, 1, 4'd5,  8, 0, 2, 3, 2'b01, 2'b10, 1, 1);
    step(0, 0, 0, 0, 4'd0,  8, 0, 2, 3, 2'b01, 2'b10, 0, 1);
    // Illegal codes
    step(0, 0, 1, 0, 4'd0,  8, 0, 2, 3, 2'b01, 2'b10, 1, 1);
    step(0, 0, 1, 0, 4'd14, 8, 0, 2, 3, 2'b01, 2'b10, 1, 1);
    step(0, 0, 0, 0, 4'd0,  8, 0, 2, 3, 2'b01, 2'b10, 0, 1);
    step(0, 0, 1, 0, 4'd15, 8, 0, 2, 3, 2'b01, 2'b10, 1, 1);
    // Third player card: 8 + 1 = 9, natural drops at three cards
    step(0, 0, 1, 0, 4'd1,  9, 0, 3, 3, 2'b00, 2'b11, 0, 1);
    step(0, 0, 1, 0, 4'd2,  9, 0, 3, 3, 2'b00, 2'b11, 1, 1);
    // Clear while err pending: err forced low
    step(0, 1, 0, 0, 4'd0,  0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    // Player A + 2 = 3, then clear with card 4 presented
    step(0, 0, 1, 0, 4'd1,  1, 0, 1, 0, 2'b00, 2'b00, 0, 1);
    step(0, 0, 1, 0, 4'd2,  3, 0, 2, 0, 2'b00, 2'b00, 0, 1);
    step(0, 1, 1, 0, 4'd4,  0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    step(0, 0, 1, 0, 4'd3,  3, 0, 1, 0, 2'b00, 2'b00, 0, 1);
    step(0, 0, 1, 0, 4'd3,  6, 0, 2, 0, 2'b00, 2'b00, 0, 1);
    step(0, 0, 1, 0, 4'd3,  9, 0, 3, 0, 2'b00, 2'b01, 0, 1);
    // Dealer 7 + 5 wraps to 2, then 6 -> 8 with three cards
    step(0, 0, 1, 1, 4'd7,  9, 7, 3, 1, 2'b00, 2'b01, 0, 1);
    step(0, 0, 1, 1, 4'd5,  9, 2, 3, 2, 2'b00, 2'b01, 0, 1);
    step(0, 0, 1, 1, 4'd6,  9, 8, 3, 3, 2'b00, 2'b11, 0, 1);
    step(0, 0, 1, 0, 4'd7,  9, 8, 3, 3, 2'b00, 2'b11, 1, 1);
    // Reset mid-round with clear and a card: everything zero, no err
    step(1, 1, 1, 1, 4'd4,  0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    // Dealer natural 8 + K, player untouched
    step(0, 0, 1, 1, 4'd8,  0, 8, 0, 1, 2'b00, 2'b00, 0, 1);
    step(0, 0, 1, 1, 4'd13, 0, 8, 0, 2, 2'b10, 2'b00, 0, 1);
    step(0, 0, 1, 0, 4'd9,  9, 8, 1, 2, 2'b10, 2'b00, 0, 1);
    step(0, 0, 0, 0, 4'd0,  9, 8, 1, 2, 2'b10, 2'b00, 0, 1);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge slow_clock);
    #2;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
